// File: rtl/smi_frame_steer_x3.sv
// Steers whole SMI frames from one input onto outputs A/B/C (or drops them),
// using the 2-bit route field of the first flit of each frame.

// Two-entry self-link double buffer: one cycle of latency, upstream Stop
// comes from a register so the steering logic never sees a combinational
// path from the downstream Stop.
module smi_frame_steer_x3_buf #(
    parameter int Width = 24
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             bufReady,
    input  logic [Width-1:0] bufData,
    output logic             bufStop,
    output logic             outReady,
    output logic [Width-1:0] outData,
    input  logic             outStop
);
    logic             mainValid;
    logic             skidValid;
    logic [Width-1:0] mainData;
    logic [Width-1:0] skidData;
    logic             inXfer;
    logic             mainFree;

    assign bufStop  = skidValid;
    assign outReady = mainValid;
    assign outData  = mainData;
    assign inXfer   = bufReady & ~skidValid;
    assign mainFree = ~mainValid | ~outStop;

    always_ff @(posedge clk) begin
        if (srst) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else if (mainFree) begin
            // When the skid entry is full, bufStop was high, so no new flit arrives.
            mainValid <= skidValid | inXfer;
            skidValid <= 1'b0;
        end else if (inXfer) begin
            skidValid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mainFree) begin
            mainData <= skidValid ? skidData : bufData;
        end else if (inXfer) begin
            skidData <= bufData;
        end
    end
endmodule

// state     | meaning
// SteerIdle | awaiting the first flit of a frame
// SteerOutA | forwarding the current frame to output A
// SteerOutB | forwarding the current frame to output B
// SteerOutC | forwarding the current frame to output C
// SteerDrop | consuming the current frame without forwarding it
module smi_frame_steer_x3 #(
    parameter int FlitWidth = 2,
    parameter int EofcMask  = 2*FlitWidth-1,
    parameter int RouteLsb  = 0
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   smiInReady,
    input  logic [7:0]             smiInEofc,
    input  logic [FlitWidth*8-1:0] smiInData,
    output logic                   smiInStop,
    output logic                   smiOutAReady,
    output logic [7:0]             smiOutAEofc,
    output logic [FlitWidth*8-1:0] smiOutAData,
    input  logic                   smiOutAStop,
    output logic                   smiOutBReady,
    output logic [7:0]             smiOutBEofc,
    output logic [FlitWidth*8-1:0] smiOutBData,
    input  logic                   smiOutBStop,
    output logic                   smiOutCReady,
    output logic [7:0]             smiOutCEofc,
    output logic [FlitWidth*8-1:0] smiOutCData,
    input  logic                   smiOutCStop,
    output logic [15:0]            dropCount
);
    localparam int DataW = FlitWidth*8;
    localparam int BufW  = DataW + 8;
    localparam logic [7:0] EofcMaskBits = 8'(EofcMask);

    typedef enum logic [2:0] {
        SteerIdle,
        SteerOutA,
        SteerOutB,
        SteerOutC,
        SteerDrop
    } steerState_t;

    steerState_t state;
    steerState_t stateNext;

    logic             inReady_q;
    logic [7:0]       inEofc_q;
    logic [DataW-1:0] inData_q;
    logic             inLast_q;
    logic             inLoad;
    logic             inXfer;
    logic             halt;
    logic             dropping;
    logic [1:0]       route;

    logic             bufReadyA;
    logic             bufReadyB;
    logic             bufReadyC;
    logic             bufStopA;
    logic             bufStopB;
    logic             bufStopC;
    logic [BufW-1:0]  bufData;
    logic [BufW-1:0]  outDataA;
    logic [BufW-1:0]  outDataB;
    logic [BufW-1:0]  outDataC;

    // Input register slice
    assign inLoad    = ~(inReady_q & halt);
    assign inXfer    = inReady_q & ~halt;
    assign smiInStop = inReady_q & halt;
    assign route     = inData_q[RouteLsb+1:RouteLsb];
    assign bufData   = {inEofc_q, inData_q};

    always_ff @(posedge clk) begin
        if (srst) begin
            inReady_q <= 1'b0;
        end else if (inLoad) begin
            inReady_q <= smiInReady;
        end
    end

    always_ff @(posedge clk) begin
        if (inLoad) begin
            inEofc_q <= smiInEofc & EofcMaskBits;
            inData_q <= smiInData;
            inLast_q <= |smiInEofc;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= SteerIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            SteerIdle: begin
                if (inXfer && !inLast_q) begin
                    case (route)
                        2'd0:    stateNext = SteerOutA;
                        2'd1:    stateNext = SteerOutB;
                        2'd2:    stateNext = SteerOutC;
                        default: stateNext = SteerDrop;
                    endcase
                end
            end
            SteerOutA, SteerOutB, SteerOutC, SteerDrop: begin
                if (inXfer && inLast_q) begin
                    stateNext = SteerIdle;
                end
            end
            default: stateNext = SteerIdle;
        endcase
    end

    // Only the buffer owning the current frame sees the flit; the header is
    // decoded combinationally so a new frame costs no idle cycle.
    always_comb begin
        bufReadyA = 1'b0;
        bufReadyB = 1'b0;
        bufReadyC = 1'b0;
        halt      = 1'b0;
        dropping  = 1'b0;
        case (state)
            SteerIdle: begin
                case (route)
                    2'd0: begin
                        bufReadyA = inReady_q;
                        halt      = bufStopA;
                    end
                    2'd1: begin
                        bufReadyB = inReady_q;
                        halt      = bufStopB;
                    end
                    2'd2: begin
                        bufReadyC = inReady_q;
                        halt      = bufStopC;
                    end
                    default: dropping = inReady_q;
                endcase
            end
            SteerOutA: begin
                bufReadyA = inReady_q;
                halt      = bufStopA;
            end
            SteerOutB: begin
                bufReadyB = inReady_q;
                halt      = bufStopB;
            end
            SteerOutC: begin
                bufReadyC = inReady_q;
                halt      = bufStopC;
            end
            SteerDrop: dropping = inReady_q;
            default: begin
                halt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            dropCount <= 16'd0;
        end else if (dropping && inXfer && inLast_q) begin
            dropCount <= dropCount + 16'd1;
        end
    end

    smi_frame_steer_x3_buf #(.Width(BufW)) uBufA (
        .clk      (clk),
        .srst     (srst),
        .bufReady (bufReadyA),
        .bufData  (bufData),
        .bufStop  (bufStopA),
        .outReady (smiOutAReady),
        .outData  (outDataA),
        .outStop  (smiOutAStop)
    );

    smi_frame_steer_x3_buf #(.Width(BufW)) uBufB (
        .clk      (clk),
        .srst     (srst),
        .bufReady (bufReadyB),
        .bufData  (bufData),
        .bufStop  (bufStopB),
        .outReady (smiOutBReady),
        .outData  (outDataB),
        .outStop  (smiOutBStop)
    );

    smi_frame_steer_x3_buf #(.Width(BufW)) uBufC (
        .clk      (clk),
        .srst     (srst),
        .bufReady (bufReadyC),
        .bufData  (bufData),
        .bufStop  (bufStopC),
        .outReady (smiOutCReady),
        .outData  (outDataC),
        .outStop  (smiOutCStop)
    );

    assign smiOutAEofc = outDataA[BufW-1:DataW];
    assign smiOutAData = outDataA[DataW-1:0];
    assign smiOutBEofc = outDataB[BufW-1:DataW];
    assign smiOutBData = outDataB[DataW-1:0];
    assign smiOutCEofc = outDataC[BufW-1:DataW];
    assign smiOutCData = outDataC[DataW-1:0];
endmodule

// File: tb/tb_smi_frame_steer_x3.sv
// Directed bench for smi_frame_steer_x3: each task drives one scenario and
// checks the captured output flits against hand-computed values.
module tb_smi_frame_steer_x3;
    logic        clk = 1'b0;
    logic        srst;
    logic        smiInReady;
    logic [7:0]  smiInEofc;
    logic [15:0] smiInData;
    logic        smiInStop;
    logic        smiOutAReady, smiOutBReady, smiOutCReady;
    logic [7:0]  smiOutAEofc, smiOutBEofc, smiOutCEofc;
    logic [15:0] smiOutAData, smiOutBData, smiOutCData;
    logic        smiOutAStop, smiOutBStop, smiOutCStop;
    logic [15:0] dropCount;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    logic inStopSeen;
    logic [23:0] qA[$], qB[$], qC[$];
    int cA[$], cB[$], cC[$], cAll[$];

    smi_frame_steer_x3 dut (
        .clk          (clk),
        .srst         (srst),
        .smiInReady   (smiInReady),
        .smiInEofc    (smiInEofc),
        .smiInData    (smiInData),
        .smiInStop    (smiInStop),
        .smiOutAReady (smiOutAReady),
        .smiOutAEofc  (smiOutAEofc),
        .smiOutAData  (smiOutAData),
        .smiOutAStop  (smiOutAStop),
        .smiOutBReady (smiOutBReady),
        .smiOutBEofc  (smiOutBEofc),
        .smiOutBData  (smiOutBData),
        .smiOutBStop  (smiOutBStop),
        .smiOutCReady (smiOutCReady),
        .smiOutCEofc  (smiOutCEofc),
        .smiOutCData  (smiOutCData),
        .smiOutCStop  (smiOutCStop),
        .dropCount    (dropCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Outputs and stops are stable between edges, so a negedge sample
    // describes the transfer happening at the following rising edge.
    always @(negedge clk) begin
        if (smiOutAReady && !smiOutAStop) begin qA.push_back({smiOutAEofc, smiOutAData}); cA.push_back(cyc); cAll.push_back(cyc); end
        if (smiOutBReady && !smiOutBStop) begin qB.push_back({smiOutBEofc, smiOutBData}); cB.push_back(cyc); cAll.push_back(cyc); end
        if (smiOutCReady && !smiOutCStop) begin qC.push_back({smiOutCEofc, smiOutCData}); cC.push_back(cyc); cAll.push_back(cyc); end
        if (smiInStop) inStopSeen = 1'b1;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearMon();
        qA.delete(); qB.delete(); qC.delete();
        cA.delete(); cB.delete(); cC.delete(); cAll.delete();
        inStopSeen = 1'b0;
    endtask

    task automatic sendFlit(input logic [15:0] d, input logic [7:0] e);
        int n;
        n = 0;
        smiInReady = 1'b1;
        smiInData  = d;
        smiInEofc  = e;
        @(negedge clk);
        while (smiInStop && n < 200) begin
            n++;
            @(negedge clk);
        end
        vecs++;
        if (smiInStop) begin
            errs++;
            $display("FAIL sendFlit_timeout data=%h smiInStop still %b after %0d cycles, need 0", d, smiInStop, n);
        end
        @(posedge clk);
        #1;
        smiInReady = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        waitCycles(3);
        srst = 1'b0;
        waitCycles(1);
        vecs++; if (smiOutAReady !== 1'b0) begin errs++; $display("FAIL reset_readyA got %b need 0", smiOutAReady); end
        vecs++; if (smiOutBReady !== 1'b0) begin errs++; $display("FAIL reset_readyB got %b need 0", smiOutBReady); end
        vecs++; if (smiOutCReady !== 1'b0) begin errs++; $display("FAIL reset_readyC got %b need 0", smiOutCReady); end
        vecs++; if (smiInStop !== 1'b0) begin errs++; $display("FAIL reset_inStop got %b need 0", smiInStop); end
        vecs++; if (dropCount !== 16'd0) begin errs++; $display("FAIL reset_dropCount got %0d need 0", dropCount); end
    endtask

    task automatic test_single_flit();
        clearMon();
        sendFlit(16'h0001, 8'h02);
        sendFlit(16'h0000, 8'h02);
        waitCycles(5);
        vecs++; if (qB.size() !== 1) begin errs++; $display("FAIL single_countB got %0d need 1", qB.size()); end
        else begin
            vecs++; if (qB[0] !== 24'h020001) begin errs++; $display("FAIL single_dataB got %h need 020001", qB[0]); end
        end
        vecs++; if (qA.size() !== 1) begin errs++; $display("FAIL single_countA got %0d need 1", qA.size()); end
        else begin
            vecs++; if (qA[0] !== 24'h020000) begin errs++; $display("FAIL single_dataA got %h need 020000", qA[0]); end
            if (cB.size() == 1) begin
                vecs++; if (cA[0] !== cB[0] + 1) begin errs++; $display("FAIL single_gap A at cycle %0d need %0d", cA[0], cB[0] + 1); end
            end
        end
        vecs++; if (qC.size() !== 0) begin errs++; $display("FAIL single_countC got %0d need 0", qC.size()); end
        vecs++; if (dropCount !== 16'd0) begin errs++; $display("FAIL single_dropCount got %0d need 0", dropCount); end
    endtask

    task automatic test_stall();
        logic [23:0] expC[4];
        logic seen;
        expC[0] = 24'h000002; expC[1] = 24'h001111; expC[2] = 24'h002222; expC[3] = 24'h013333;
        seen = 1'b0;
        clearMon();
        fork
            begin
                sendFlit(16'h0002, 8'h00);
                sendFlit(16'h1111, 8'h00);
                sendFlit(16'h2222, 8'h00);
                sendFlit(16'h3333, 8'h01);
            end
            begin
                @(posedge clk);
                #1;
                smiOutCStop = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (smiInStop) seen = 1'b1;
                end
                waitCycles(2);
                smiOutCStop = 1'b0;
            end
        join
        waitCycles(8);
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL stall_inStop got %b need 1 within 3 cycles", seen); end
        vecs++; if (qC.size() !== 4) begin errs++; $display("FAIL stall_countC got %0d need 4", qC.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                vecs++; if (qC[i] !== expC[i]) begin errs++; $display("FAIL stall_dataC[%0d] got %h need %h", i, qC[i], expC[i]); end
            end
        end
        vecs++; if (qA.size() + qB.size() !== 0) begin errs++; $display("FAIL stall_otherPorts got %0d flits need 0", qA.size() + qB.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d[12];
        logic [7:0]  e[12];
        logic [23:0] expA[6];
        logic [23:0] expC[3];
        d = '{16'h0000, 16'hA001, 16'hA002, 16'h0002, 16'hC001, 16'hC003,
              16'h0004, 16'hA011, 16'hA012, 16'h0000, 16'h0000, 16'h0000};
        e = '{8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h06,
              8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        expA = '{24'h000000, 24'h00A001, 24'h01A002, 24'h000004, 24'h00A011, 24'h01A012};
        expC = '{24'h000002, 24'h00C001, 24'h02C003};
        clearMon();
        for (int i = 0; i < 9; i++) sendFlit(d[i], e[i]);
        waitCycles(6);
        vecs++; if (inStopSeen !== 1'b0) begin errs++; $display("FAIL b2b_inStop got %b need 0", inStopSeen); end
        vecs++; if (cAll.size() !== 9) begin errs++; $display("FAIL b2b_total got %0d need 9", cAll.size()); end
        else begin
            vecs++; if (cAll[8] - cAll[0] !== 8) begin errs++; $display("FAIL b2b_contiguous span %0d need 8", cAll[8] - cAll[0]); end
        end
        vecs++; if (qA.size() !== 6) begin errs++; $display("FAIL b2b_countA got %0d need 6", qA.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                vecs++; if (qA[i] !== expA[i]) begin errs++; $display("FAIL b2b_dataA[%0d] got %h need %h", i, qA[i], expA[i]); end
            end
        end
        vecs++; if (qC.size() !== 3) begin errs++; $display("FAIL b2b_countC got %0d need 3", qC.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                vecs++; if (qC[i] !== expC[i]) begin errs++; $display("FAIL b2b_dataC[%0d] got %h need %h", i, qC[i], expC[i]); end
            end
        end
        vecs++; if (qB.size() !== 0) begin errs++; $display("FAIL b2b_countB got %0d need 0", qB.size()); end
    endtask

    task automatic test_drop();
        clearMon();
        sendFlit(16'h0003, 8'h00);
        sendFlit(16'h0000, 8'h00);
        sendFlit(16'h0001, 8'h01);
        sendFlit(16'h0007, 8'h02);
        waitCycles(5);
        vecs++; if (cAll.size() !== 0) begin errs++; $display("FAIL drop_outputs got %0d flits need 0", cAll.size()); end
        vecs++; if (inStopSeen !== 1'b0) begin errs++; $display("FAIL drop_inStop got %b need 0", inStopSeen); end
        vecs++; if (dropCount !== 16'd2) begin errs++; $display("FAIL drop_dropCount got %0d need 2", dropCount); end
    endtask

    task automatic test_order();
        clearMon();
        smiOutAStop = 1'b1;
        fork
            begin
                sendFlit(16'h0000, 8'h00);
                sendFlit(16'hB001, 8'h00);
                sendFlit(16'hB002, 8'h00);
                sendFlit(16'hB003, 8'h01);
                sendFlit(16'h0001, 8'h02);
            end
            begin
                waitCycles(20);
                vecs++; if (qB.size() !== 0) begin errs++; $display("FAIL order_earlyB got %0d flits need 0", qB.size()); end
                vecs++; if (smiInStop !== 1'b1) begin errs++; $display("FAIL order_inStop got %b need 1", smiInStop); end
                smiOutAStop = 1'b0;
            end
        join
        waitCycles(8);
        vecs++; if (qA.size() !== 4) begin errs++; $display("FAIL order_countA got %0d need 4", qA.size()); end
        else begin
            vecs++; if (qA[3] !== 24'h01B003) begin errs++; $display("FAIL order_lastA got %h need 01B003", qA[3]); end
        end
        vecs++; if (qB.size() !== 1) begin errs++; $display("FAIL order_countB got %0d need 1", qB.size()); end
        else begin
            vecs++; if (qB[0] !== 24'h020001) begin errs++; $display("FAIL order_dataB got %h need 020001", qB[0]); end
            if (qA.size() == 4) begin
                vecs++; if (cB[0] <= cA[3]) begin errs++; $display("FAIL order_sequence B at %0d need after A at %0d", cB[0], cA[3]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        sendFlit(16'h0000, 8'h00);
        sendFlit(16'h5555, 8'h00);
        srst = 1'b1;
        waitCycles(1);
        srst = 1'b0;
        vecs++; if ({smiOutAReady, smiOutBReady, smiOutCReady} !== 3'b000) begin errs++; $display("FAIL rstmid_ready got %b need 000", {smiOutAReady, smiOutBReady, smiOutCReady}); end
        vecs++; if (smiInStop !== 1'b0) begin errs++; $display("FAIL rstmid_inStop got %b need 0", smiInStop); end
        vecs++; if (dropCount !== 16'd0) begin errs++; $display("FAIL rstmid_dropCount got %0d need 0", dropCount); end
        clearMon();
        sendFlit(16'h0001, 8'h00);
        sendFlit(16'h6666, 8'h02);
        waitCycles(6);
        vecs++; if (qB.size() !== 2) begin errs++; $display("FAIL rstmid_countB got %0d need 2", qB.size()); end
        else begin
            vecs++; if (qB[0] !== 24'h000001) begin errs++; $display("FAIL rstmid_dataB0 got %h need 000001", qB[0]); end
            vecs++; if (qB[1] !== 24'h026666) begin errs++; $display("FAIL rstmid_dataB1 got %h need 026666", qB[1]); end
        end
        vecs++; if (qA.size() + qC.size() !== 0) begin errs++; $display("FAIL rstmid_otherPorts got %0d flits need 0", qA.size() + qC.size()); end
    endtask

    initial begin
        srst        = 1'b1;
        smiInReady  = 1'b0;
        smiInEofc   = 8'h00;
        smiInData   = 16'h0000;
        smiOutAStop = 1'b0;
        smiOutBStop = 1'b0;
        smiOutCStop = 1'b0;
        inStopSeen  = 1'b0;
        test_reset();
        test_single_flit();
        test_stall();
        test_back_to_back();
        test_drop();
        test_order();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
